// File: rtl/heichips25_sa_pkg.sv
// Shared types and constants for the systolic-array host sequencer.
package heichips25_sa_pkg;

    localparam int N          = 4;
    localparam int N_ELEMS    = N * N;
    localparam int LOAD_BYTES = 2 * N_ELEMS;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        GAP,
        LOADW,
        LOADI,
        WAIT,
        STORE,
        DRAIN
    } sa_seq_state_t;

    // Weights arrive row-major but the array wants them column-major:
    // slot k reads W[k mod 4][k div 4], i.e. buffer index (k mod 4)*4 + k div 4.
    function automatic logic [3:0] w_slot_index(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage

// File: rtl/heichips25_sa_result_buf.sv
// 16-entry capture buffer for the array results, one write and one read port.
module heichips25_sa_result_buf
    import heichips25_sa_pkg::*;
#(
    parameter int OUTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [3:0]          i_wr_idx,
    input  logic [OUTWIDTH-1:0] i_wr_data,
    input  logic [3:0]          i_rd_idx,
    output logic [OUTWIDTH-1:0] o_rd_data
);

    logic [OUTWIDTH-1:0] r_mem [N_ELEMS];

    // Capture one result per enabled cycle; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEMS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/heichips25_sa_sequencer.sv
// Host-side sequencer: buffers W and A from a byte stream, loads the
// systolic array without stalls, collects its 16 results and streams them out.
module heichips25_sa_sequencer
    import heichips25_sa_pkg::*;
#(
    parameter int BITWIDTH       = 8,
    parameter int OUTWIDTH       = 2 * BITWIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUTWIDTH-1:0] res_data,
    output logic                res_last,
    output logic [BITWIDTH-1:0] sa_data_in,
    output logic                sa_load_weights,
    output logic                sa_load_inputs,
    output logic                sa_store_outputs,
    input  logic [OUTWIDTH-1:0] sa_results,
    input  logic                sa_valid_out,
    output logic                busy,
    output logic                timeout_err
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    sa_seq_state_t       r_state;
    sa_seq_state_t       w_state_nxt;
    logic [BITWIDTH-1:0] r_ibuf [LOAD_BYTES];
    logic [4:0]          r_fill_cnt;
    logic [3:0]          r_slot;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [3:0]          r_rd_cnt;
    logic                r_timeout_err;
    logic                r_cap_vld_p1;
    logic [3:0]          r_cap_idx_p1;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_wait_expired;
    logic                w_load_w;
    logic                w_load_i;
    logic                w_store;
    logic                w_res_valid;
    logic [OUTWIDTH-1:0] w_rd_data;

    assign w_wait_nxt     = r_wait_cnt + 1'b1;
    assign w_wait_expired = (w_wait_nxt == WAIT_W'(TIMEOUT_CYCLES));
    assign w_accept       = in_valid & w_in_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; load/store phases run back to back with no stall.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load_w    = 1'b0;
        w_load_i    = 1'b0;
        w_store     = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_state_nxt = FILL;
            end
            FILL: begin
                w_in_ready = 1'b1;
                if (in_valid && r_fill_cnt == 5'(LOAD_BYTES - 1)) w_state_nxt = GAP;
            end
            GAP: begin
                w_state_nxt = LOADW;
            end
            LOADW: begin
                w_load_w = 1'b1;
                if (r_slot == 4'd15) w_state_nxt = LOADI;
            end
            LOADI: begin
                w_load_i = 1'b1;
                if (r_slot == 4'd15) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (sa_valid_out) begin
                    w_state_nxt = STORE;
                end else if (w_wait_expired) begin
                    w_state_nxt = IDLE;
                end
            end
            STORE: begin
                w_store = 1'b1;
                if (r_slot == 4'd15) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_res_valid = 1'b1;
                if (res_ready && r_rd_cnt == 4'd15) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte buffer, phase counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LOAD_BYTES; i++) begin
                r_ibuf[i] <= '0;
            end
            r_fill_cnt    <= '0;
            r_slot        <= '0;
            r_wait_cnt    <= '0;
            r_rd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ibuf[r_fill_cnt] <= in_data;
                r_fill_cnt         <= r_fill_cnt + 1'b1;
            end
            if (r_state == WAIT && !sa_valid_out && w_wait_expired) begin
                r_timeout_err <= 1'b1;
            end else if (w_accept && r_state == IDLE) begin
                r_timeout_err <= 1'b0;
            end
            if (w_load_w || w_load_i || w_store) begin
                r_slot <= r_slot + 1'b1;
            end else begin
                r_slot <= '0;
            end
            r_wait_cnt <= (r_state == WAIT) ? w_wait_nxt : '0;
            if (w_res_valid && res_ready) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Stage p1: the array registers its results, so capture lags the store index by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_vld_p1 <= 1'b0;
            r_cap_idx_p1 <= '0;
        end else begin
            r_cap_vld_p1 <= w_store;
            r_cap_idx_p1 <= r_slot;
        end
    end

    heichips25_sa_result_buf #(
        .OUTWIDTH (OUTWIDTH)
    ) u_rbuf (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_wr_en   (r_cap_vld_p1),
        .i_wr_idx  (r_cap_idx_p1),
        .i_wr_data (sa_results),
        .i_rd_idx  (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    // in_ready is forced low while reset is held so every output reads 0 during reset.
    assign in_ready         = w_in_ready & reset_n;
    assign sa_load_weights  = w_load_w;
    assign sa_load_inputs   = w_load_i;
    assign sa_store_outputs = w_store;
    assign sa_data_in       = w_load_w ? r_ibuf[{1'b0, w_slot_index(r_slot)}] :
                              w_load_i ? r_ibuf[{1'b1, r_slot}] : '0;
    assign res_valid        = w_res_valid;
    assign res_data         = w_res_valid ? w_rd_data : '0;
    assign res_last         = w_res_valid && (r_rd_cnt == 4'd15);
    assign busy             = (r_state != IDLE);
    assign timeout_err      = r_timeout_err;

endmodule
